// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary comparison transmit path.
// Pure declarations; no timing or flow control of its own.
package unary_pkg;

  localparam int UNARY_W = 16;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } ustream_state_t;

  // Values of 16 and above naturally saturate to all ones.
  function automatic logic [UNARY_W-1:0] therm(input logic [4:0] v);
    logic [UNARY_W-1:0] t;
    t = '0;
    for (int i = 0; i < UNARY_W; i++) begin
      t[i] = (5'(i) < v);
    end
    return t;
  endfunction

  function automatic logic [3:0] bitrev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

endpackage

// File: rtl/unary_therm_enc.sv
// Combinational 5-bit binary to 16-bit thermometer encoder, saturating above 16.
// Zero latency, no flow control.
module unary_therm_enc
  import unary_pkg::*;
(
  input  logic [4:0]         val,
  output logic [UNARY_W-1:0] code
);

  assign code = therm(val);

endmodule

// File: rtl/unary_stream_gen.sv
// Expands one accepted level into DIM registered (a, b) thermometer word pairs.
// First word one cycle after accept, 1 word/clk; words hold while out_ready is low.
module unary_stream_gen
  import unary_pkg::*;
#(
  parameter int W     = 16,
  parameter int DIM   = 1024,
  parameter int PHASE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_level,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           a_out,
  output logic [W-1:0]           b_out,
  output logic [$clog2(DIM)-1:0] out_idx,
  output logic                   out_last
);

  localparam int KW = $clog2(DIM);

  ustream_state_t state, state_nxt;
  logic [KW-1:0]  k, k_nxt;
  logic           accept, adv;
  logic [3:0]     thr;
  logic [W-1:0]   a_code, b_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign adv    = out_valid && out_ready;

  // Both encoders look at the word being loaded next, not the one on the outputs.
  assign k_nxt = accept ? '0 : k + 1'b1;
  assign thr   = bitrev4(k_nxt[3:0] + 4'(PHASE));

  unary_therm_enc u_enc_a (
    .val  (in_level),
    .code (a_code)
  );

  unary_therm_enc u_enc_b (
    .val  ({1'b0, thr}),
    .code (b_code)
  );

  // a_out doubles as the latched level: loaded once per stream, constant after.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      a_out    <= '0;
      b_out    <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      k        <= '0;
      a_out    <= a_code;
      b_out    <= b_code;
      out_last <= 1'b0;
    end else if (adv) begin
      if (out_last) begin
        k        <= '0;
        a_out    <= '0;
        b_out    <= '0;
        out_last <= 1'b0;
      end else begin
        k        <= k_nxt;
        b_out    <= b_code;
        out_last <= (k_nxt == KW'(DIM - 1));
      end
    end
  end

  assign out_idx = k;

endmodule

// File: tb/tb_unary_stream_gen.sv
// Three configurations of unary_stream_gen checked against a behavioural stream model.
module tb_unary_stream_gen;

  localparam int N = 3;
  localparam int DIMS [N] = '{16, 16, 1024};
  localparam int PHS  [N] = '{0, 3, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [4:0]   in_level [N];
  logic [15:0]  a_out [N];
  logic [15:0]  b_out [N];
  logic [9:0]   idx [N];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [$clog2(DIMS[g])-1:0] idx_l;
    logic [15:0] a_l, b_l;
    unary_stream_gen #(.W(16), .DIM(DIMS[g]), .PHASE(PHS[g])) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_level  (in_level[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .a_out     (a_l),
      .b_out     (b_l),
      .out_idx   (idx_l),
      .out_last  (out_last[g])
    );
    assign idx[g]   = 10'(idx_l);
    assign a_out[g] = a_l;
    assign b_out[g] = b_l;
  end

  // Reference model: per instance, whether a stream is in flight, its level and word index.
  bit busy [N];
  int lvl  [N];
  int mk   [N];
  int hs   [N];
  int ones [N];
  int lasts [N];
  bit started = 1'b0;

  function automatic logic [15:0] therm_m(int v);
    return (v >= 16) ? 16'hFFFF : 16'((1 << v) - 1);
  endfunction

  function automatic int thr_m(int k, int ph);
    int x;
    int r;
    x = (k + ph) % 16;
    r = 0;
    for (int b = 0; b < 4; b++) if (((x >> b) & 1) != 0) r += 8 >> b;
    return r;
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", name, i, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst[i] && out_valid[i] && out_ready[i]) begin
        hs[i]++;
        if (a_out[i] > b_out[i]) ones[i]++;
        if (out_last[i]) lasts[i]++;
      end
      if (rst[i]) begin
        busy[i] = 1'b0;
        mk[i]   = 0;
      end else if (!busy[i]) begin
        if (in_valid[i]) begin
          busy[i] = 1'b1;
          lvl[i]  = (in_level[i] > 5'd16) ? 16 : int'(in_level[i]);
          mk[i]   = 0;
        end
      end else if (out_ready[i]) begin
        if (mk[i] == DIMS[i] - 1) begin
          busy[i] = 1'b0;
          mk[i]   = 0;
        end else begin
          mk[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < N; i++) begin
        chk("in_ready", i, 32'(in_ready[i]), 32'(!busy[i]));
        chk("out_valid", i, 32'(out_valid[i]), 32'(busy[i]));
        if (busy[i]) begin
          chk("a_out", i, 32'(a_out[i]), 32'(therm_m(lvl[i])));
          chk("b_out", i, 32'(b_out[i]), 32'(therm_m(thr_m(mk[i], PHS[i]))));
          chk("out_idx", i, 32'(idx[i]), 32'(mk[i]));
          chk("out_last", i, 32'(out_last[i]), 32'(mk[i] == DIMS[i] - 1));
        end
      end
    end
  end

  task automatic send(int i, int lv);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready[i] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("send_timeout", i, 32'(t < 5000), 32'd1);
    in_valid[i] = 1'b1;
    in_level[i] = 5'(lv);
    @(negedge clk);
    in_valid[i] = 1'b0;
    in_level[i] = 5'($urandom);
  endtask

  // Random in_valid/in_level while streaming must be ignored.
  task automatic drain(int i, bit rnd);
    int t;
    t = 0;
    while (busy[i] && t < 20000) begin
      out_ready[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_level[i]  = 5'($urandom);
      in_valid[i]  = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", i, 32'(t < 20000), 32'd1);
    in_valid[i]  = 1'b0;
    out_ready[i] = 1'b1;
  endtask

  task automatic clr(int i);
    hs[i]    = 0;
    ones[i]  = 0;
    lasts[i] = 0;
  endtask

  initial begin
    int thr_exp [16];
    int t;
    thr_exp = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    rst       = '1;
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < N; i++) begin
      in_level[i] = '0;
      clr(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = '0;
    started = 1'b1;
    for (int i = 0; i < N; i++) begin
      chk("rst_in_ready", i, 32'(in_ready[i]), 32'd1);
      chk("rst_out_valid", i, 32'(out_valid[i]), 32'd0);
      chk("rst_a", i, 32'(a_out[i]), 32'd0);
      chk("rst_b", i, 32'(b_out[i]), 32'd0);
      chk("rst_idx", i, 32'(idx[i]), 32'd0);
      chk("rst_last", i, 32'(out_last[i]), 32'd0);
    end

    // Pin the model's threshold sequence and thermometer code.
    for (int k = 0; k < 16; k++) chk("model_thr", 0, 32'(thr_m(k, 0)), 32'(thr_exp[k]));
    chk("model_therm5", 0, 32'(therm_m(5)), 32'h001F);
    chk("model_thr_ph3", 1, 32'(thr_m(0, 3)), 32'd12);

    // Level 5, DIM=16, full throughput.
    clr(0);
    send(0, 5);
    chk("t1_a", 0, 32'(a_out[0]), 32'h001F);
    chk("t1_b0", 0, 32'(b_out[0]), 32'h0000);
    drain(0, 1'b0);
    chk("t1_hs", 0, 32'(hs[0]), 32'd16);
    chk("t1_lasts", 0, 32'(lasts[0]), 32'd1);

    // Level 0 and level 16 extremes.
    clr(0);
    send(0, 0);
    chk("t2_a0", 0, 32'(a_out[0]), 32'h0000);
    drain(0, 1'b1);
    chk("t2_ones0", 0, 32'(ones[0]), 32'd0);
    clr(0);
    send(0, 16);
    chk("t2_a16", 0, 32'(a_out[0]), 32'hFFFF);
    drain(0, 1'b1);
    chk("t2_ones16", 0, 32'(ones[0]), 32'd16);

    // Saturation of out-of-range level.
    clr(0);
    send(0, 31);
    chk("t3_a31", 0, 32'(a_out[0]), 32'hFFFF);
    drain(0, 1'b0);
    chk("t3_hs", 0, 32'(hs[0]), 32'd16);

    // Reset coincident with in_valid: level must not be taken.
    @(negedge clk);
    rst[0] = 1'b1; in_valid[0] = 1'b1; in_level[0] = 5'd9;
    @(negedge clk);
    rst[0] = 1'b0; in_valid[0] = 1'b0;
    chk("rstwin_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("rstwin_ready", 0, 32'(in_ready[0]), 32'd1);

    // Long stream with random stalls, DIM=1024.
    clr(2);
    send(2, 9);
    drain(2, 1'b1);
    chk("t4_hs", 2, 32'(hs[2]), 32'd1024);
    chk("t4_lasts", 2, 32'(lasts[2]), 32'd1);

    // Reset mid-stream at k=7, then a fresh stream from k=0.
    send(0, 11);
    t = 0;
    while (mk[0] != 7 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t5_reach7", 0, 32'(idx[0]), 32'd7);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("t5_valid", 0, 32'(out_valid[0]), 32'd0);
    chk("t5_ready", 0, 32'(in_ready[0]), 32'd1);
    chk("t5_a", 0, 32'(a_out[0]), 32'd0);
    chk("t5_b", 0, 32'(b_out[0]), 32'd0);
    chk("t5_idx", 0, 32'(idx[0]), 32'd0);
    chk("t5_last", 0, 32'(out_last[0]), 32'd0);
    rst[0] = 1'b0;
    clr(0);
    send(0, 3);
    chk("t5_new_idx", 0, 32'(idx[0]), 32'd0);
    chk("t5_new_a", 0, 32'(a_out[0]), 32'h0007);
    drain(0, 1'b1);
    chk("t5_hs", 0, 32'(hs[0]), 32'd16);

    // PHASE=3, level 8.
    clr(1);
    send(1, 8);
    chk("t6_b0", 1, 32'(b_out[1]), 32'h0FFF);
    chk("t6_a", 1, 32'(a_out[1]), 32'h00FF);
    drain(1, 1'b1);
    chk("t6_ones", 1, 32'(ones[1]), 32'd8);
    chk("t6_hs", 1, 32'(hs[1]), 32'd16);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
